// File: rtl/i2c_eeprom_slave.sv
// I2C slave EEPROM model: 2**ADDR_W x 8 memory behind an oversampled scl/sda bus.
// Supports random/sequential write and read with pointer wrap; drives sda open-drain only.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         ADDR_W   = 7,
  parameter logic [7:0] INIT_VAL = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  logic              sda,
  output logic              busy,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_pulse
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_WORD_ADDR, S_WORD_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [6:0]        rx_sr;
  logic [7:0]        tx_sr;
  logic [3:0]        bit_cnt;
  logic              ack_on;
  logic              rw;
  logic              drive_low;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  assign sda = drive_low ? 1'b0 : 1'bz;

  // Stage p0/p1: two-flop synchronizers; p2: previous value for edge detection.
  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl;    scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda;    sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  =  scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 &  scl_p2;
  assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
  assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;
  assign rx_byte   = {rx_sr, sda_p1};
  assign rd_byte   = mem[ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      ack_on    <= 1'b0;
      rw        <= 1'b0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      wr_pulse  <= 1'b0;
      rd_pulse  <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else begin
      wr_pulse <= 1'b0;
      rd_pulse <= 1'b0;
      if (scl_rise) rx_sr <= rx_byte[6:0];
      if (start_det) begin
        state     <= S_DEV_ADDR;
        bit_cnt   <= '0;
        ack_on    <= 1'b0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_det) begin
        state     <= S_IDLE;
        ack_on    <= 1'b0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_DEV_ADDR: if (scl_rise) begin
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (rx_sr == DEV_ADDR) begin
                rw    <= sda_p1;
                busy  <= 1'b1;
                state <= S_DEV_ACK;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // ACK spans one fall-to-fall window; the closing fall also starts a read.
          S_DEV_ACK: if (scl_fall) begin
            if (!ack_on) begin
              ack_on    <= 1'b1;
              drive_low <= 1'b1;
            end else begin
              ack_on <= 1'b0;
              if (rw) begin
                tx_sr     <= {rd_byte[6:0], 1'b0};
                drive_low <= ~rd_byte[7];
                bit_cnt   <= 4'd1;
                ptr       <= ptr + ADDR_W'(1);
                rd_pulse  <= 1'b1;
                state     <= S_RD_DATA;
              end else begin
                drive_low <= 1'b0;
                bit_cnt   <= '0;
                state     <= S_WORD_ADDR;
              end
            end
          end
          S_WORD_ADDR: if (scl_rise) begin
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              ptr     <= rx_byte[ADDR_W-1:0];
              state   <= S_WORD_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_WORD_ACK, S_WR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              ack_on    <= 1'b1;
              drive_low <= 1'b1;
            end else begin
              ack_on    <= 1'b0;
              drive_low <= 1'b0;
              bit_cnt   <= '0;
              state     <= S_WR_DATA;
            end
          end
          S_WR_DATA: if (scl_rise) begin
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              mem[ptr] <= rx_byte;
              wr_addr  <= ptr;
              wr_pulse <= 1'b1;
              ptr      <= ptr + ADDR_W'(1);
              state    <= S_WR_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              drive_low <= 1'b0;
              bit_cnt   <= '0;
              state     <= S_RD_ACK;
            end else begin
              drive_low <= ~tx_sr[7];
              tx_sr     <= {tx_sr[6:0], 1'b0};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end
          S_RD_ACK: if (scl_rise) begin
            if (!sda_p1) begin
              tx_sr    <= rd_byte;
              bit_cnt  <= '0;
              ptr      <= ptr + ADDR_W'(1);
              rd_pulse <= 1'b1;
              state    <= S_RD_DATA;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bus-level master tasks plus a pulse scoreboard.
module tb_i2c_eeprom_slave;
  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       busy, wr_pulse, rd_pulse;
  logic [6:0] wr_addr;

  int checks = 0;
  int errors = 0;
  int drive_viol = 0;
  bit watch = 1'b0;
  logic [6:0] exp_wr[$];
  int         exp_rd[$];
  logic [6:0] e_addr;

  pullup(sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_eeprom_slave #(.DEV_ADDR(7'h50), .ADDR_W(7), .INIT_VAL(8'hFF)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .busy(busy), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .rd_pulse(rd_pulse)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_pulse) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_pulse_unexpected: got wr_addr=%0h expected no write", wr_addr);
        end else begin
          e_addr = exp_wr.pop_front();
          if (wr_addr !== e_addr) begin
            errors++;
            $display("FAIL wr_addr: got %0h expected %0h", wr_addr, e_addr);
          end
        end
      end
      if (rd_pulse) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_pulse_unexpected: got pulse expected none");
        end else begin
          void'(exp_rd.pop_front());
        end
      end
    end
  end

  always @(negedge clk) if (watch && !m_low && sda === 1'b0) drive_viol++;

  task automatic q_wait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      m_low = 1'b0; q_wait();
      scl = 1'b1;   q_wait();
    end
    m_low = 1'b1; q_wait();
    scl = 1'b0;   q_wait();
  endtask

  task automatic bus_stop();
    m_low = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    m_low = 1'b0; q_wait();
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    m_low = ~b; q_wait();
    scl = 1'b1; q_wait();
    s = sda;    q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d, output logic ninth);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(master_ack ? 1'b0 : 1'b1, ninth);
  endtask

  logic       ack, ninth, s;
  logic [7:0] d;

  initial begin
    rst = 1'b1; scl = 1'b1; m_low = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_wr_pulse", int'(wr_pulse), 0);
    check("reset_rd_pulse", int'(rd_pulse), 0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_sda_released", int'(sda === 1'b1), 1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single-byte write of 0x3C at 0x10
    bus_start();
    write_byte(8'hA0, ack); check("t1_dev_ack", int'(ack), 0);
    check("t1_busy_after_ack", int'(busy), 1);
    write_byte(8'h10, ack); check("t1_word_ack", int'(ack), 0);
    exp_wr.push_back(7'h10);
    write_byte(8'h3C, ack); check("t1_data_ack", int'(ack), 0);
    check("t1_busy_before_stop", int'(busy), 1);
    bus_stop();
    check("t1_busy_after_stop", int'(busy), 0);

    // Random read of 0x10 with repeated start
    bus_start();
    write_byte(8'hA0, ack); check("t2_dev_ack", int'(ack), 0);
    write_byte(8'h10, ack); check("t2_word_ack", int'(ack), 0);
    bus_start();
    exp_rd.push_back(1);
    write_byte(8'hA1, ack); check("t2_rd_dev_ack", int'(ack), 0);
    read_byte(1'b0, d, ninth);
    check("t2_data", int'(d), 8'h3C);
    check("t2_ninth_released", int'(ninth), 1);
    bus_stop();
    check("t2_busy_idle", int'(busy), 0);

    // Sequential write across the top of memory, then read with wrap
    bus_start();
    write_byte(8'hA0, ack); check("t3_dev_ack", int'(ack), 0);
    write_byte(8'h7E, ack); check("t3_word_ack", int'(ack), 0);
    exp_wr.push_back(7'h7E);
    write_byte(8'h11, ack); check("t3_d0_ack", int'(ack), 0);
    exp_wr.push_back(7'h7F);
    write_byte(8'h22, ack); check("t3_d1_ack", int'(ack), 0);
    bus_stop();
    bus_start();
    write_byte(8'hA0, ack); check("t3_setptr_ack", int'(ack), 0);
    write_byte(8'h7E, ack); check("t3_setptr_word_ack", int'(ack), 0);
    bus_start();
    exp_rd.push_back(1); exp_rd.push_back(2); exp_rd.push_back(3);
    write_byte(8'hA1, ack); check("t3_rd_dev_ack", int'(ack), 0);
    read_byte(1'b1, d, ninth); check("t3_byte0", int'(d), 8'h11);
    read_byte(1'b1, d, ninth); check("t3_byte1", int'(d), 8'h22);
    read_byte(1'b0, d, ninth); check("t3_byte2_wrap", int'(d), 8'hFF);
    check("t3_ninth_released", int'(ninth), 1);
    bus_stop();

    // Address mismatch: never driven, nothing written
    watch = 1'b1;
    bus_start();
    write_byte(8'hA2, ack); check("t4_dev_nack", int'(ack), 1);
    check("t4_busy", int'(busy), 0);
    write_byte(8'h10, ack); check("t4_byte1_nack", int'(ack), 1);
    write_byte(8'h55, ack); check("t4_byte2_nack", int'(ack), 1);
    bus_stop();
    watch = 1'b0;
    check("t4_sda_never_driven", drive_viol, 0);

    // Aborted write: STOP after four bits of the second data byte
    bus_start();
    write_byte(8'hA0, ack); check("t5_dev_ack", int'(ack), 0);
    write_byte(8'h20, ack); check("t5_word_ack", int'(ack), 0);
    exp_wr.push_back(7'h20);
    write_byte(8'h5A, ack); check("t5_d0_ack", int'(ack), 0);
    bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b1, s); bit_xfer(1'b1, s);
    bus_stop();
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    bus_start();
    exp_rd.push_back(4); exp_rd.push_back(5);
    write_byte(8'hA1, ack); check("t5_rd_dev_ack", int'(ack), 0);
    read_byte(1'b1, d, ninth); check("t5_byte_written", int'(d), 8'h5A);
    read_byte(1'b0, d, ninth); check("t5_next_untouched", int'(d), 8'hFF);
    bus_stop();

    // Reset while the slave drives the MSB (0) of 0x5A
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    bus_start();
    exp_rd.push_back(6);
    write_byte(8'hA1, ack); check("t6_rd_dev_ack", int'(ack), 0);
    check("t6_slave_drives_low", int'(sda === 1'b0), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("t6_sda_released_on_rst", int'(sda === 1'b1), 1);
    check("t6_busy_on_rst", int'(busy), 0);
    scl = 1'b1; m_low = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus_start();
    write_byte(8'hA0, ack); check("t6_post_dev_ack", int'(ack), 0);
    write_byte(8'h20, ack);
    bus_start();
    exp_rd.push_back(7);
    write_byte(8'hA1, ack);
    read_byte(1'b0, d, ninth); check("t6_mem_reinit", int'(d), 8'hFF);
    bus_stop();

    repeat (10) @(posedge clk);
    #1;
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Behavioural/synthesizable I2C slave EEPROM model on the far end of the master's `scl`/`sda` bus.
- Consumes address, write and read transactions; stores bytes in an internal 128x8 array; returns them on reads.
- Used as the bus-side counterpart of the master in system simulation and FPGA loopback.
- Runs on the system clock and oversamples the bus; it is not clocked by `scl`.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address this slave answers to.
- ADDR_W, 7, word-address width; memory depth = 2**ADDR_W bytes.
- INIT_VAL, 8'hFF, value of every memory byte after reset.

Ports:
- clk  input  1  system clock (100 MHz nominal).
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data, open-drain; the slave only drives 0 or 'z'.
- busy  output  1  high from an accepted (ACKed) device address to the next STOP/START.
- wr_pulse  output  1  one-clk pulse per byte written into memory.
- wr_addr  output  ADDR_W  memory address of the last write; valid with wr_pulse.
- rd_pulse  output  1  one-clk pulse per byte loaded for transmission.

Behaviour:
- Reset (async, rst=1):
  - All state is cleared; state=IDLE; sda released (z).
  - busy=0, wr_pulse=0, rd_pulse=0, wr_addr=0, word pointer ptr=0.
  - All memory bytes = INIT_VAL.
- Input sync:
  - scl and sda each pass through 2-FF synchronizers, then a third stage for edge detection.
  - All decisions use the synchronized values.
  - Bus-to-decision latency is 3 clk.
- Bus events (synchronized):
  - SCL rise: scl_s 0->1.
  - SCL fall: scl_s 1->0.
  - START: sda_s 1->0 while scl_s=1.
  - STOP: sda_s 0->1 while scl_s=1.
  - START/STOP take priority over every state.
- START, from any state (repeated start included): bit counter=0, state=DEV_ADDR, sda released.
- STOP, from any state: state=IDLE, busy=0, sda released. ptr is retained.
- Bit order:
  - MSB first, in both directions.
  - Data is sampled on SCL rise.
  - The slave changes sda only on SCL fall.
- States:
  - IDLE: ignore everything except START.
  - DEV_ADDR: shift 8 bits, {addr[6:0], rw}.
    - On the 8th rise, if addr==DEV_ADDR, go to DEV_ACK and set busy=1.
    - On mismatch, go to IDLE; no ACK is ever driven.
  - DEV_ACK: drive sda=0 from the next SCL fall to the following SCL fall.
    - rw=0: go to WORD_ADDR.
    - rw=1: go to RD_DATA; load shift register from mem[ptr] and pulse rd_pulse.
  - WORD_ADDR: shift 8 bits. On the 8th rise, ptr = byte[ADDR_W-1:0]; upper bits are ignored. Go to WORD_ACK.
  - WORD_ACK: ACK as in DEV_ACK, then go to WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th rise:
    - mem[ptr] = byte; wr_addr = ptr; pulse wr_pulse.
    - ptr = ptr+1, wrapping modulo 2**ADDR_W (7'h7F -> 7'h00).
    - Go to WR_ACK.
  - WR_ACK: ACK as above, then go to WR_DATA (sequential write, unlimited length).
  - RD_DATA:
    - On each SCL fall (including the fall ending DEV_ACK), drive the current MSB: 0 -> drive 0, 1 -> release.
    - After the 8th bit's fall, release sda and go to RD_ACK.
    - ptr increments (with wrap) when the byte is loaded.
  - RD_ACK: sample sda on SCL rise.
    - 0 (master ACK): load mem[ptr], pulse rd_pulse, go to RD_DATA.
    - 1 (NACK): go to IDLE and stay released until START.
- Write-then-read:
  - Word address is sent, then a repeated START with rw=1.
  - Reads begin at the written ptr.
  - A write phase with zero data bytes only sets ptr.
- Simultaneous events:
  - START/STOP detected in the same clk as an SCL edge cannot occur (scl_s is stable).
  - A STOP mid-byte discards the partial byte; nothing is written.
- Reset mid-transfer: sda is released immediately (asynchronous); the memory contents revert to INIT_VAL.
- sda output: sda = drive_low ? 1'b0 : 1'bz. The slave never drives 1.

Test Plan:
- Write: START, 0xA0 (0x50,w), word 0x10, data 0x3C, STOP -> ACK low on all three 9th clocks; one wr_pulse with wr_addr=0x10; busy high from the first ACK until STOP.
- Random read: START, 0xA0, 0x10, repeated START, 0xA1, master NACK, STOP -> slave returns 0x3C MSB first; sda released during the 9th clock; state returns to IDLE.
- Sequential read with wrap: preload 0x7E=0x11 and 0x7F=0x22, set ptr=0x7E, read 3 bytes with ACK,ACK,NACK -> 0x11, 0x22, then 0xFF (INIT_VAL at 0x00); three rd_pulse.
- Address mismatch: START, 0xA2 (0x51) -> sda never driven; busy=0; wr_pulse never asserts; following bytes ignored until the next START.
- Aborted write: STOP after 4 data bits of the second byte -> only the first byte is written; exactly one wr_pulse; no memory change at ptr+1.
- Reset during read: assert rst while the slave drives a 0 bit -> sda goes to z within the same cycle; busy=0; a subsequent read of the previously written address returns 0xFF.
